uart_rx_sampler: RTL and testbench
==================================

# uart_rx_sampler

Front end of the UART receive path: synchronises `uart_rxd`, divides `pclk` into a 16x oversampling tick, and locks the oversampling phase to the start-bit falling edge. It emits one-cycle `voting_edge` pulses at oversample phases 6/7/8 and a `sample_edge` pulse at bit centre. It also produces the 3-sample majority bit `rx_data`. All of these drive the receive FSM directly; the FSM's `voting_shift_en` comes back in to clock the voter.

## Interface
- `DIV_W`, 16, width of the baud divisor.
- `pclk`  in  1  system clock; all logic on rising edge.
- `preset`  in  1  reset, synchronous, active-high.
- `utrrst`  in  1  receive enable; low forces HUNT.
- `uart_rxd`  in  1  asynchronous serial input.
- `divisor`  in  DIV_W  pclk cycles per 16x tick; 0 treated as 1; sampled live.
- `frame_bits`  in  4  bits per frame including start and stop, legal 3..13.
- `voting_shift_en`  in  1  from FSM; shifts the voter register.
- `rx_data`  out  1  majority of voter register.
- `voting_edge`  out  1  one-cycle pulse at phases 6, 7, 8.
- `sample_edge`  out  1  one-cycle pulse at bit centre, after third vote.
- `rx_locked`  out  1  high in LOCKED state.

## Operation
- Synchroniser: 2 flops `rxd_s1`→`rxd_s`, plus `rxd_prev` for edge detect. All reset to 1.
- Prescaler `pcnt` (DIV_W bits):
  - `tick` = LOCKED & (`pcnt` == max(`divisor`,1)−1).
  - On `tick`, `pcnt`←0; otherwise `pcnt`←`pcnt`+1.
  - If `divisor` is lowered below `pcnt` mid-count, `pcnt` runs on to wrap (no lock-up; one long tick).
- Phase counter `phase` (4 bits): +1 mod 16 on each `tick`.
- Bit counter `bcnt` (4 bits): +1 on `sample_edge`, saturates at 15.
- States, HUNT (reset) and LOCKED:
  - HUNT → LOCKED: `utrrst` & `rxd_prev`==1 & `rxd_s`==0. The next cycle has `pcnt`=0, `phase`=0, `bcnt`=0.
  - LOCKED → HUNT (false start): `sample_edge` & `bcnt`==0 & `rx_data`==1.
  - LOCKED → HUNT (end of frame): `sample_edge` & `bcnt`+1 ≥ `frame_bits` & `rx_data`==1.
  - LOCKED stays LOCKED when `rx_data`==0 at the stop position (break or framing error). Sampling free-runs one `sample_edge` per bit until a sampled 1.
  - Any state → HUNT: `utrrst`==0. Next cycle clears `pcnt`, `phase`, `bcnt`.
- Voter `vote[2:0]`:
  - LOCKED: on `voting_shift_en`, `vote`←{`vote[1:0]`,`rxd_s`}.
  - HUNT: `vote`←{3{`rxd_s`}} every cycle, so `rx_data` tracks the idle line and the FSM WAIT/BREAK states can observe line release.
- `rx_data` = (v0&v1)|(v0&v2)|(v1&v2), combinational from flops.
- `voting_edge` = `tick` & `phase`∈{6,7,8}, combinational.
- `sample_edge`: registered; high the cycle after the `tick` at `phase`==8, so it sees the updated voter.
- Reset values:
  - Outputs: `rx_data`=1, `voting_edge`=0, `sample_edge`=0, `rx_locked`=0.
  - Internal: `vote`=111, all counters 0.

## Timing
- `uart_rxd` fall to `rxd_s` low: 2 cycles. Entry to LOCKED: +1 cycle.
- With divisor D:
  - First `voting_edge` occurs 7·D−1 cycles after LOCKED entry.
  - `voting_edge` pulses are spaced D cycles apart.
  - `sample_edge` follows the third vote by 1 cycle.
  - Bit period is 16·D cycles.
- `sample_edge` and a LOCKED→HUNT transition occur in the same cycle. A falling edge in the following cycle relocks (back-to-back frames).
- `preset` takes priority over `utrrst`, which takes priority over all transitions.

## Test plan
- Reset and idle line: hold `preset` 2 cycles → all outputs at reset values, `rx_locked`=0, `rx_data`=1, no edges for 1000 cycles.
- D=4, `frame_bits`=10, byte 0x55 → `voting_edge` triplets 4 cycles apart. 10 `sample_edge`s 64 cycles apart. `rx_data` sequence 0,1,0,1,0,1,0,1,0,1. HUNT after the 10th.
- Glitch start: 20-cycle low pulse, D=4 → one `sample_edge` with `rx_data`=1, then HUNT. No further edges.
- Single-sample noise: invert `uart_rxd` around phase 7 only → `rx_data` is unchanged at `sample_edge`.
- Break: line low for 30 bit times, `frame_bits`=10 → `sample_edge` continues every 64 cycles and `rx_locked` stays high. Release high → HUNT at the next `sample_edge`. `rx_data` goes to 1.
- Mid-frame `utrrst` drop at bit 4 → HUNT the next cycle and no further edges. Reassert with the line idle → no lock until the next falling edge.

Source files
------------

// File: rtl/uart_rx_sampler_if.sv
// Bundle between the UART receive front end and the receive FSM that consumes its edges.
// The master side is the FSM/line side; the slave side is the sampler itself.
interface uart_rx_sampler_if #(
  parameter int DIV_W = 16
) ();
  logic             utrrst;
  logic             uart_rxd;
  logic [DIV_W-1:0] divisor;
  logic [3:0]       frame_bits;
  logic             voting_shift_en;
  logic             rx_data;
  logic             voting_edge;
  logic             sample_edge;
  logic             rx_locked;

  modport master (
    output utrrst, uart_rxd, divisor, frame_bits, voting_shift_en,
    input  rx_data, voting_edge, sample_edge, rx_locked
  );

  modport slave (
    input  utrrst, uart_rxd, divisor, frame_bits, voting_shift_en,
    output rx_data, voting_edge, sample_edge, rx_locked
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// UART receive front end: input synchroniser, 16x oversampling prescaler phase-locked to the
// start-bit falling edge, 3-sample majority voter and the voting/sample strobes for the receive FSM.
module uart_rx_sampler #(
  parameter int DIV_W = 16
) (
  input logic             pclk,
  input logic             preset,
  uart_rx_sampler_if.slave bus
);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic             rxd_s1;
  logic             rxd_s;
  logic             rxd_prev;
  logic [DIV_W-1:0] pcnt;
  logic [DIV_W-1:0] div_m1_s;
  logic [3:0]       phase;
  logic [3:0]       bcnt;
  logic [2:0]       vote;
  logic             sample_edge_r;
  logic             tick_s;
  logic             start_s;
  logic             frame_done_s;
  logic             rx_data_s;
  logic             voting_edge_s;
  logic             rx_locked_s;

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge pclk) begin
    if (preset) begin
      rxd_s1   <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_s1   <= bus.uart_rxd;
      rxd_s    <= rxd_s1;
      rxd_prev <= rxd_s;
    end
  end

  assign start_s      = rxd_prev & ~rxd_s;
  assign div_m1_s     = (bus.divisor == {DIV_W{1'b0}}) ? {DIV_W{1'b0}} : (bus.divisor - DIV_W'(1));
  assign frame_done_s = (({1'b0, bcnt} + 5'd1) >= {1'b0, bus.frame_bits});

  // State register.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_r <= HUNT;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; a sampled 1 at start position is a false start, at/after stop it ends the frame.
  always_comb begin
    next_state_s = state_r;
    if (!bus.utrrst) begin
      next_state_s = HUNT;
    end else begin
      case (state_r)
        HUNT: begin
          if (start_s) begin
            next_state_s = LOCKED;
          end else begin
            next_state_s = HUNT;
          end
        end
        LOCKED: begin
          if (sample_edge_r && rx_data_s && ((bcnt == 4'd0) || frame_done_s)) begin
            next_state_s = HUNT;
          end else begin
            next_state_s = LOCKED;
          end
        end
        default: next_state_s = HUNT;
      endcase
    end
  end

  // Output decode from the state and counter flops.
  always_comb begin
    rx_locked_s   = (state_r == LOCKED);
    tick_s        = rx_locked_s && (pcnt == div_m1_s);
    voting_edge_s = tick_s && ((phase == 4'd6) || (phase == 4'd7) || (phase == 4'd8));
    rx_data_s     = majority3(vote);
  end

  // Prescaler, phase and bit counters; held cleared while hunting so a lock starts at zero.
  always_ff @(posedge pclk) begin
    if (preset || !bus.utrrst || (state_r == HUNT)) begin
      pcnt  <= {DIV_W{1'b0}};
      phase <= 4'd0;
      bcnt  <= 4'd0;
    end else begin
      if (tick_s) begin
        pcnt  <= {DIV_W{1'b0}};
        phase <= phase + 4'd1;
      end else begin
        pcnt  <= pcnt + DIV_W'(1);
      end
      if (sample_edge_r && (bcnt != 4'd15)) begin
        bcnt <= bcnt + 4'd1;
      end
    end
  end

  // Bit-centre strobe, one cycle after the phase-8 vote so the FSM sees the updated majority.
  always_ff @(posedge pclk) begin
    if (preset || !bus.utrrst) begin
      sample_edge_r <= 1'b0;
    end else begin
      sample_edge_r <= tick_s && (phase == 4'd8);
    end
  end

  // Voter: follows the idle line while hunting so line release is visible to the FSM.
  always_ff @(posedge pclk) begin
    if (preset) begin
      vote <= 3'b111;
    end else if (state_r == HUNT) begin
      vote <= {3{rxd_s}};
    end else if (bus.voting_shift_en) begin
      vote <= {vote[1:0], rxd_s};
    end
  end

  assign bus.rx_data     = rx_data_s;
  assign bus.voting_edge = voting_edge_s;
  assign bus.sample_edge = sample_edge_r;
  assign bus.rx_locked   = rx_locked_s;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler: expected bit values are queued as each bit is driven
// and compared at every sample_edge, alongside strobe spacing and latency checks.
module tb_uart_rx_sampler;
  localparam int DIV_W = 16;

  logic pclk = 1'b0;
  logic preset;

  uart_rx_sampler_if #(.DIV_W(DIV_W)) bus ();

  uart_rx_sampler #(.DIV_W(DIV_W)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  always #5 pclk = ~pclk;

  // The receive FSM shifts the voter on every voting edge.
  assign bus.voting_shift_en = bus.voting_edge;

  int   n_checks = 0;
  int   n_fail = 0;
  logic sb[$];
  int   cur_d = 4;
  bit   mon_en = 1'b0;
  int   cyc = 0;
  int   last_ve = 0;
  int   last_se = 0;
  int   lock_cyc = 0;
  int   votes_in_bit = 0;
  int   n_vote = 0;
  int   n_sample = 0;
  bit   first_ve_pending = 1'b0;
  bit   have_se = 1'b0;
  logic prev_locked = 1'b0;
  logic exp_bit;
  int   s0;
  int   v0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge pclk);
      #2;
    end
  endtask

  task automatic set_div(input int d);
    bus.divisor = DIV_W'(d);
    cur_d = (d == 0) ? 1 : d;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) step(1);
    check("sb_drain", sb.size(), 0);
  endtask

  // Start + 8 data (LSB first) + stop; optional phase-7 glitch on one bit, optional utrrst drop.
  task automatic send_frame(input logic [7:0] data, input int noise_bit, input int drop_bit);
    logic [9:0] bits;
    bits = {1'b1, data, 1'b0};
    for (int k = 0; k < 10; k++) begin
      if (k == drop_bit) begin
        bus.uart_rxd = bits[k];
        step(2);
        bus.utrrst = 1'b0;
        step(1);
        check("drop_hunt", bus.rx_locked, 1'b0);
        bus.uart_rxd = 1'b1;
        return;
      end
      sb.push_back(bits[k]);
      for (int c = 0; c < 16 * cur_d; c++) begin
        if (k == noise_bit && c >= 8 * cur_d - 3 && c < 8 * cur_d + 1) bus.uart_rxd = ~bits[k];
        else bus.uart_rxd = bits[k];
        step(1);
      end
    end
  endtask

  always @(negedge pclk) begin
    cyc++;
    if (mon_en) begin
      if (bus.rx_locked && !prev_locked) begin
        lock_cyc         = cyc;
        first_ve_pending = 1'b1;
        have_se          = 1'b0;
        votes_in_bit     = 0;
      end
      if (bus.voting_edge) begin
        n_vote++;
        check("ve_locked", bus.rx_locked, 1'b1);
        if (first_ve_pending) begin
          check("first_ve_latency", cyc - lock_cyc, 7 * cur_d - 1);
          first_ve_pending = 1'b0;
        end else if (votes_in_bit > 0) begin
          check("ve_spacing", cyc - last_ve, cur_d);
        end
        votes_in_bit++;
        last_ve = cyc;
      end
      if (bus.sample_edge) begin
        n_sample++;
        check("se_after_vote", cyc - last_ve, 1);
        check("se_votes", votes_in_bit, 3);
        if (have_se) check("se_spacing", cyc - last_se, 16 * cur_d);
        have_se      = 1'b1;
        last_se      = cyc;
        votes_in_bit = 0;
        if (sb.size() == 0) begin
          check("sb_extra_sample", bus.sample_edge, 1'b0);
        end else begin
          exp_bit = sb.pop_front();
          check("rx_data", bus.rx_data, exp_bit);
        end
      end
      prev_locked = bus.rx_locked;
    end
  end

  initial begin
    preset         = 1'b1;
    bus.utrrst     = 1'b1;
    bus.uart_rxd   = 1'b1;
    bus.frame_bits = 4'd10;
    set_div(4);
    step(2);
    check("rst_rx_data", bus.rx_data, 1'b1);
    check("rst_voting_edge", bus.voting_edge, 1'b0);
    check("rst_sample_edge", bus.sample_edge, 1'b0);
    check("rst_locked", bus.rx_locked, 1'b0);
    preset = 1'b0;
    mon_en = 1'b1;

    step(1000);
    check("idle_votes", n_vote, 0);
    check("idle_samples", n_sample, 0);
    check("idle_locked", bus.rx_locked, 1'b0);
    check("idle_rx_data", bus.rx_data, 1'b1);

    // Back-to-back frames at D=4.
    s0 = n_sample;
    send_frame(8'h55, -1, -1);
    send_frame(8'hA3, -1, -1);
    step(20);
    wait_drain(200);
    check("frames_samples", n_sample - s0, 20);
    check("frames_hunt", bus.rx_locked, 1'b0);

    // Divisor 0 behaves as 1, then D=5.
    s0 = n_sample;
    set_div(0);
    send_frame(8'hC3, -1, -1);
    set_div(5);
    send_frame(8'h3C, -1, -1);
    step(20);
    wait_drain(200);
    check("div_samples", n_sample - s0, 20);
    check("div_hunt", bus.rx_locked, 1'b0);

    // 20-cycle glitch start: one sample of 1, then back to hunting.
    set_div(4);
    s0 = n_sample;
    v0 = n_vote;
    sb.push_back(1'b1);
    bus.uart_rxd = 1'b0;
    step(20);
    bus.uart_rxd = 1'b1;
    step(300);
    wait_drain(10);
    check("glitch_samples", n_sample - s0, 1);
    check("glitch_votes", n_vote - v0, 3);
    check("glitch_hunt", bus.rx_locked, 1'b0);

    // Single-sample noise at phase 7 must be outvoted.
    send_frame(8'hA5, 4, -1);
    send_frame(8'hA5, 6, -1);
    step(20);
    wait_drain(200);
    check("noise_hunt", bus.rx_locked, 1'b0);

    // Break: 30 bit times low keeps sampling, release ends it at the next sample.
    s0 = n_sample;
    for (int i = 0; i < 30; i++) sb.push_back(1'b0);
    bus.uart_rxd = 1'b0;
    step(20 * 16 * cur_d);
    check("break_locked", bus.rx_locked, 1'b1);
    step(10 * 16 * cur_d);
    sb.push_back(1'b1);
    bus.uart_rxd = 1'b1;
    step(200);
    wait_drain(10);
    check("break_samples", n_sample - s0, 31);
    check("break_hunt", bus.rx_locked, 1'b0);
    check("break_rx_data", bus.rx_data, 1'b1);

    // utrrst drop at bit 4, then reassert on an idle line.
    s0 = n_sample;
    v0 = n_vote;
    send_frame(8'h0F, -1, 4);
    step(300);
    check("drop_samples", n_sample - s0, 4);
    check("drop_votes", n_vote - v0, 12);
    bus.utrrst = 1'b1;
    step(300);
    check("reassert_locked", bus.rx_locked, 1'b0);
    check("reassert_samples", n_sample - s0, 4);
    send_frame(8'h96, -1, -1);
    step(20);
    wait_drain(200);
    check("relock_samples", n_sample - s0, 14);
    check("relock_hunt", bus.rx_locked, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
